audio_stream_ctrl: RTL
======================

AUDIO_STREAM_CTRL -- requirements
Module: audio_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the sample width per channel, matching the codec readdata/writedata width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of output FIFO entries (stereo pairs); it is a power of 2 and at least 2.
REQ-003 SHALL have ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  allows new sample capture and zero-fill.
- bypass  in  1  1 = route captured samples straight to the FIFO, skipping the processing engine.
- read_ready  in  1  codec has an ADC sample pair available.
- readdata_left, readdata_right  in  DATA_W each  codec ADC sample pair.
- read  out  1  pop one ADC pair from the codec.
- write_ready  in  1  codec can accept a DAC pair.
- write  out  1  push one DAC pair to the codec.
- writedata_left, writedata_right  out  DATA_W each  DAC sample pair.
- proc_valid  out  1  sample offered to the processing engine.
- proc_left, proc_right  out  DATA_W each  offered sample pair.
- proc_ready  in  1  engine accepts the offered pair.
- res_valid  in  1  engine result valid; single-cycle pulse.
- res_left, res_right  in  DATA_W each  engine result pair.
- overflow_cnt  out  16  count of dropped ADC samples.
- underflow_cnt  out  16  count of zero-filled DAC writes.
- busy  out  1  capture FSM is not in IDLE.

Function
REQ-004 SHALL run a capture FSM with three states: IDLE, REQ and WAIT_RES.
REQ-005 In IDLE with enable=1 and read_ready=1, the FSM SHALL assert read for exactly one cycle and capture readdata_left/right in that same cycle.
REQ-006 In the REQ-005 case, the next state SHALL depend on FIFO occupancy and bypass, both sampled that cycle:
- FIFO not full, bypass=0: latch the pair and go to REQ.
- FIFO not full, bypass=1: push the pair into the FIFO next edge and stay in IDLE.
- FIFO full: discard the pair, increment overflow_cnt, stay in IDLE.
REQ-007 "Full" SHALL use the registered occupancy only, with no look-ahead for a same-cycle pop.
REQ-008 In REQ, proc_valid SHALL be 1 and proc_left/right SHALL hold the latched pair stable; when proc_ready=1, the FSM SHALL go to WAIT_RES.
REQ-009 In WAIT_RES, when res_valid=1 the FSM SHALL push res_left/res_right into the FIFO and return to IDLE; res_valid in any other state SHALL be ignored.
REQ-010 Only the capture FSM pushes, so a push from WAIT_RES SHALL never find the FIFO full; no overflow check applies there.
REQ-011 proc_valid SHALL be 0 outside REQ.
REQ-012 The FIFO SHALL be DEPTH-entry, first-in first-out, with wrapping pointers and occupancy 0..DEPTH.
REQ-013 A same-cycle push and pop SHALL leave occupancy unchanged.
REQ-014 When write_ready=1 and the FIFO is non-empty, write SHALL be 1 combinationally, writedata SHALL be the FIFO head, and the head SHALL pop on that edge.
REQ-015 When write_ready=1, the FIFO is empty and enable=1, write SHALL be 1 with writedata=0 and underflow_cnt SHALL increment.
REQ-016 When write_ready=1, the FIFO is empty and enable=0, write SHALL be 0.
REQ-017 With write=0, writedata SHALL be 0.
REQ-018 Both counters SHALL saturate at 16'hFFFF.
REQ-019 Deasserting enable SHALL stop new reads from IDLE only; an in-flight sample SHALL complete through REQ/WAIT_RES, and the FIFO SHALL keep draining.
REQ-020 bypass SHALL be sampled only at the capture cycle; changing it mid-flight SHALL not affect the in-flight sample.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 Latency in bypass mode SHALL be: capture at cycle N, FIFO-visible at N+1, write possible at N+1.

Reset
REQ-023 While reset=1, regardless of clock, the block SHALL force: state=IDLE, FIFO empty with pointers 0, latched pair 0, and overflow_cnt=underflow_cnt=0.
REQ-024 During reset, read, proc_valid and busy SHALL be 0, and write SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the in-flight sample; after release, res_valid SHALL be ignored until a new capture.

Verification
REQ-026 Bypass stream: enable=1, bypass=1, read_ready=1 with left=24'h000111 and right=24'h000222, write_ready=1 one cycle later. Required: read pulses once, and the next cycle write=1 with the same pair.
REQ-027 Engine path: bypass=0, proc_ready held 0 for 3 cycles. Required: proc_valid and data stay stable for those 3 cycles; then res_valid pulses with 24'h00ABCD, which is written out in FIFO order.
REQ-028 Overflow: hold write_ready=0 and fill 4 pairs in bypass, then read_ready=1 twice. Required: read pulses twice, overflow_cnt=2, and the FIFO contents are unchanged.
REQ-029 Underflow: FIFO empty, enable=1, write_ready=1 for 5 cycles. Required: write=1 with data 0 each cycle and underflow_cnt=5; with enable=0, write=0 and the counter holds.
REQ-030 Simultaneous push/pop with FIFO at 3: occupancy stays 3 and order is preserved. Reset asserted in WAIT_RES: all outputs go to 0 immediately, and a late res_valid is not pushed.

Source files
------------

// File: rtl/audio_stream_ctrl.sv
// Codec audio bridge: captures ADC pairs, optionally routes them through an external
// processing engine, and queues results in a small FIFO that feeds the DAC side.
module audio_stream_ctrl #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              bypass,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              proc_valid,
  output logic [DATA_W-1:0] proc_left,
  output logic [DATA_W-1:0] proc_right,
  input  logic              proc_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_left,
  input  logic [DATA_W-1:0] res_right,
  output logic [15:0]       overflow_cnt,
  output logic [15:0]       underflow_cnt,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RES} state_t;

  state_t        state_q, state_d;
  pair_t         lat_q, lat_d;
  pair_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   ovf_q, ovf_d, unf_q, unf_d;

  logic  full, empty, capture, push, pop, zero_fill;
  pair_t push_data, head;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Reset gates the combinational handshakes so nothing leaks out while held.
  assign capture   = (state_q == IDLE) && enable && read_ready && !reset;
  assign pop       = write_ready && !empty && !reset;
  assign zero_fill = write_ready && empty && enable && !reset;

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    ovf_d      = ovf_q;
    push       = 1'b0;
    push_data  = '0;
    proc_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          if (full) begin
            ovf_d = (ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
          end else if (bypass) begin
            push      = 1'b1;
            push_data = '{l: readdata_left, r: readdata_right};
          end else begin
            lat_d   = '{l: readdata_left, r: readdata_right};
            state_d = REQ;
          end
        end
      end
      REQ: begin
        proc_valid = 1'b1;
        if (proc_ready) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        // Single sample in flight, so the FIFO always has room for the result.
        if (res_valid) begin
          push      = 1'b1;
          push_data = '{l: res_left, r: res_right};
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    unf_d = (zero_fill && unf_q != 16'hFFFF) ? unf_q + 16'd1 : unf_q;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign read            = capture;
  assign write           = pop | zero_fill;
  assign writedata_left  = pop ? head.l : '0;
  assign writedata_right = pop ? head.r : '0;
  assign proc_left       = lat_q.l;
  assign proc_right      = lat_q.r;
  assign overflow_cnt    = ovf_q;
  assign underflow_cnt   = unf_q;
  assign busy            = (state_q != IDLE);

endmodule
